taxi_pcie_us_vsec_apb_ext: RTL and testbench

Second-generation UltraScale PCIe vendor-specific extended capability that bridges host config-space accesses to an APB register space. Compared with the first generation, it supports 32- or 64-bit APB data, a full 32-bit address register, and a separate control/status register with busy, done, PSLVERR and overrun flags. It also filters by PCIe function number and adds an optional APB timeout. It sits between the PCIe hard IP `cfg_ext_*` port and an APB interconnect, in the `clk` domain of the PCIe user interface.

---
 rtl/taxi_pcie_us_vsec_apb_ext.sv | 242 ++++++++++++++++++++++++
 tb/tb_taxi_pcie_us_vsec_apb_ext.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/taxi_pcie_us_vsec_apb_ext.sv
// taxi_pcie_us_vsec_apb_ext
// PCIe vendor-specific extended capability that bridges host config-space
// accesses (UltraScale cfg_ext_* port) to an APB manager port.
//
// Optional feature: define TAXI_PCIE_VSEC_APB_TIMEOUT_EN to abort an APB
// access that has not seen pready after TIMEOUT cycles in ACCESS.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   m_apb_*                    APB manager (paddr, pprot, psel, penable, pwrite,
//                              pwdata, pstrb, pauser, pwuser, prdata, pready, pslverr)
//   cfg_ext_read_received      config read strobe
//   cfg_ext_write_received     config write strobe
//   cfg_ext_register_number    dword index
//   cfg_ext_function_number    target function
//   cfg_ext_write_data/_byte_enable  config write payload
//   cfg_ext_read_data/_valid   registered read response, one cycle after strobe
module taxi_pcie_us_vsec_apb_ext #(
  parameter logic [15:0] EXT_CAP_ID       = 16'h000B,
  parameter logic [3:0]  EXT_CAP_VERSION  = 4'h1,
  parameter logic [11:0] EXT_CAP_OFFSET   = 12'h480,
  parameter logic [11:0] EXT_CAP_NEXT     = 12'h000,
  parameter logic [15:0] EXT_CAP_VSEC_ID  = 16'h00FF,
  parameter logic [3:0]  EXT_CAP_VSEC_REV = 4'h2,
  parameter logic [7:0]  FUNC_NUM         = 8'h00,
  parameter logic [15:0] TIMEOUT          = 16'd4096,
  parameter int unsigned ADDR_W           = 32,
  parameter int unsigned DATA_W           = 32,
  parameter int unsigned STRB_W           = DATA_W / 8,
  parameter int unsigned AUSER_W          = 1,
  parameter int unsigned WUSER_W          = 1
) (
  input  logic               clk,
  input  logic               rst,

  output logic [ADDR_W-1:0]  m_apb_paddr,
  output logic [2:0]         m_apb_pprot,
  output logic               m_apb_psel,
  output logic               m_apb_penable,
  output logic               m_apb_pwrite,
  output logic [DATA_W-1:0]  m_apb_pwdata,
  output logic [STRB_W-1:0]  m_apb_pstrb,
  output logic [AUSER_W-1:0] m_apb_pauser,
  output logic [WUSER_W-1:0] m_apb_pwuser,
  input  logic [DATA_W-1:0]  m_apb_prdata,
  input  logic               m_apb_pready,
  input  logic               m_apb_pslverr,

  input  logic               cfg_ext_read_received,
  input  logic               cfg_ext_write_received,
  input  logic [9:0]         cfg_ext_register_number,
  input  logic [7:0]         cfg_ext_function_number,
  input  logic [31:0]        cfg_ext_write_data,
  input  logic [3:0]         cfg_ext_write_byte_enable,
  output logic [31:0]        cfg_ext_read_data,
  output logic               cfg_ext_read_data_valid
);

  if (ADDR_W == 0 || ADDR_W > 32 || !(DATA_W == 32 || DATA_W == 64) || STRB_W * 8 != DATA_W) begin : g_bad_cfg
    $fatal(1, "taxi_pcie_us_vsec_apb_ext: unsupported APB width combination");
  end

  localparam logic [9:0]  BASE_IDX = 10'(EXT_CAP_OFFSET >> 2);
  localparam logic [11:0] VSEC_LEN = 12'h018;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

  state_t       state_q, state_d;
  logic [31:0]  addr_q, addr_d;
  logic [63:0]  data_q, data_d;
  logic [7:0]   strb_q, strb_d;
  logic         done_q, done_d, slverr_q, slverr_d, tmo_q, tmo_d;
  logic         ovr_q, ovr_d, last_wr_q, last_wr_d;
  logic         pwrite_q, pwrite_d, psel_q, psel_d, penable_q, penable_d;
  logic [31:0]  rd_data_q, rd_data_d;
  logic         rd_valid_q, rd_valid_d;
  logic [9:0]   offset;
  logic         hit, busy;

`ifdef TAXI_PCIE_VSEC_APB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = TIMEOUT - 16'd1;
  logic [15:0]  cnt_q, cnt_d;
`else
  localparam logic [15:0] timeout_unused = TIMEOUT;
`endif

  assign offset = cfg_ext_register_number - BASE_IDX;
  assign hit    = (cfg_ext_function_number == FUNC_NUM) && (offset < 10'd6);
  assign busy   = (state_q != ST_IDLE);

  // Config decode, APB sequencing and next-state for every register
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    strb_d     = strb_q;
    done_d     = done_q;
    slverr_d   = slverr_q;
    tmo_d      = tmo_q;
    ovr_d      = ovr_q;
    last_wr_d  = last_wr_q;
    pwrite_d   = pwrite_q;
    rd_data_d  = '0;
    rd_valid_d = 1'b0;
`ifdef TAXI_PCIE_VSEC_APB_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif

    if (cfg_ext_read_received && hit) begin
      rd_valid_d = 1'b1;
      case (offset)
        10'd0:   rd_data_d = {EXT_CAP_NEXT, EXT_CAP_VERSION, EXT_CAP_ID};
        10'd1:   rd_data_d = {VSEC_LEN, EXT_CAP_VSEC_REV, EXT_CAP_VSEC_ID};
        10'd2:   rd_data_d = addr_q;
        10'd3:   rd_data_d = {26'd0, last_wr_q, ovr_q, tmo_q, slverr_q, done_q, busy};
        10'd4:   rd_data_d = data_q[31:0];
        10'd5:   rd_data_d = (DATA_W == 64) ? data_q[63:32] : 32'd0;
        default: rd_data_d = '0;
      endcase
    end

    if (cfg_ext_write_received && hit) begin
      if (busy) begin
        // Register writes cannot be honoured mid-transfer; flag them instead
        if (offset >= 10'd2) ovr_d = 1'b1;
      end else begin
        case (offset)
          10'd2: addr_d = cfg_ext_write_data;
          10'd3: begin
            done_d   = 1'b0;
            slverr_d = 1'b0;
            tmo_d    = 1'b0;
            ovr_d    = 1'b0;
            if (cfg_ext_write_data[1] || cfg_ext_write_data[0]) begin
              state_d   = ST_SETUP;
              pwrite_d  = cfg_ext_write_data[1];
              last_wr_d = cfg_ext_write_data[1];
`ifdef TAXI_PCIE_VSEC_APB_TIMEOUT_EN
              cnt_d     = '0;
`endif
            end
          end
          10'd4: begin
            data_d[31:0] = cfg_ext_write_data;
            strb_d[3:0]  = cfg_ext_write_byte_enable;
          end
          10'd5: begin
            if (DATA_W == 64) begin
              data_d[63:32] = cfg_ext_write_data;
              strb_d[7:4]   = cfg_ext_write_byte_enable;
            end
          end
          default: ;
        endcase
      end
    end

    case (state_q)
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (m_apb_pready) begin
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          slverr_d = m_apb_pslverr;
          if (!pwrite_q) data_d = 64'(m_apb_prdata);
        end
`ifdef TAXI_PCIE_VSEC_APB_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      default: ;
    endcase

    psel_d    = (state_d != ST_IDLE);
    penable_d = (state_d == ST_ACCESS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      strb_q     <= '0;
      done_q     <= 1'b0;
      slverr_q   <= 1'b0;
      tmo_q      <= 1'b0;
      ovr_q      <= 1'b0;
      last_wr_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
`ifdef TAXI_PCIE_VSEC_APB_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      strb_q     <= strb_d;
      done_q     <= done_d;
      slverr_q   <= slverr_d;
      tmo_q      <= tmo_d;
      ovr_q      <= ovr_d;
      last_wr_q  <= last_wr_d;
      pwrite_q   <= pwrite_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
`ifdef TAXI_PCIE_VSEC_APB_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  // Upper strobe nibble only exists on a 64-bit bus
  if (DATA_W == 32) begin : g_d32
    logic unused_hi;
    assign unused_hi = ^strb_q[7:4];
  end

  assign m_apb_paddr             = addr_q[ADDR_W-1:0];
  assign m_apb_pprot             = 3'b010;
  assign m_apb_psel              = psel_q;
  assign m_apb_penable           = penable_q;
  assign m_apb_pwrite            = pwrite_q;
  assign m_apb_pwdata            = data_q[DATA_W-1:0];
  assign m_apb_pstrb             = strb_q[STRB_W-1:0];
  assign m_apb_pauser            = '0;
  assign m_apb_pwuser            = '0;
  assign cfg_ext_read_data       = rd_data_q;
  assign cfg_ext_read_data_valid = rd_valid_q;

endmodule

// File: tb/tb_taxi_pcie_us_vsec_apb_ext.sv
// Self-checking bench for taxi_pcie_us_vsec_apb_ext (64-bit APB data build).
module tb_taxi_pcie_us_vsec_apb_ext;

  localparam int B = 'h480 >> 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic        psel, penable, pwrite;
  logic [63:0] pwdata;
  logic [7:0]  pstrb;
  logic [0:0]  pauser, pwuser;
  logic [63:0] prdata;
  logic        pready, pslverr;
  logic        rd_rcv, wr_rcv;
  logic [9:0]  reg_num;
  logic [7:0]  fn_num;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic [31:0] rdata;
  logic        rvalid;

  always #5 clk = ~clk;

  taxi_pcie_us_vsec_apb_ext #(
    .TIMEOUT(16'd16), .ADDR_W(32), .DATA_W(64), .STRB_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .m_apb_paddr(paddr), .m_apb_pprot(pprot), .m_apb_psel(psel), .m_apb_penable(penable),
    .m_apb_pwrite(pwrite), .m_apb_pwdata(pwdata), .m_apb_pstrb(pstrb),
    .m_apb_pauser(pauser), .m_apb_pwuser(pwuser),
    .m_apb_prdata(prdata), .m_apb_pready(pready), .m_apb_pslverr(pslverr),
    .cfg_ext_read_received(rd_rcv), .cfg_ext_write_received(wr_rcv),
    .cfg_ext_register_number(reg_num), .cfg_ext_function_number(fn_num),
    .cfg_ext_write_data(wdata), .cfg_ext_write_byte_enable(wbe),
    .cfg_ext_read_data(rdata), .cfg_ext_read_data_valid(rvalid)
  );

  int total = 0;
  int bad = 0;

  // APB slave behaviour knobs and observation log
  int          slv_wait = 0;
  logic        slv_hang = 1'b0;
  logic        slv_err = 1'b0;
  logic [63:0] slv_rdata = '0;
  int          psel_cycles = 0;
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [63:0] wdat;
    logic [7:0]  strb;
    logic [2:0]  prot;
  } apb_t;
  apb_t log_q[$];

  // Reference model of the software-visible register file
  logic [31:0] m_addr;
  logic [63:0] m_data;
  logic [7:0]  m_strb;
  logic m_done, m_err, m_tmo, m_ovr, m_wr, m_busy, m_op_wr;

  initial begin : slave
    int acc;
    acc = 0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    forever begin
      @(posedge clk); #1;
      if (psel) psel_cycles++;
      if (psel && penable) begin
        if (!slv_hang && acc == slv_wait) begin
          pready = 1'b1; pslverr = slv_err; prdata = slv_rdata;
          log_q.push_back('{paddr, pwrite, pwdata, pstrb, pprot});
        end else begin
          pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
        end
        acc++;
      end else begin
        pready = 1'b0; pslverr = 1'b0; acc = 0;
      end
    end
  end

  task automatic model_reset();
    m_addr = '0; m_data = '0; m_strb = '0;
    m_done = 0; m_err = 0; m_tmo = 0; m_ovr = 0; m_wr = 0; m_busy = 0; m_op_wr = 0;
  endtask

  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] be);
    int off;
    off = idx - B;
    if (off < 0 || off > 5) return;
    if (m_busy) begin
      if (off >= 2) m_ovr = 1;
      return;
    end
    case (off)
      2: m_addr = d;
      3: begin
        m_done = 0; m_err = 0; m_tmo = 0; m_ovr = 0;
        if (d[1]) begin m_busy = 1; m_op_wr = 1; m_wr = 1; end
        else if (d[0]) begin m_busy = 1; m_op_wr = 0; m_wr = 0; end
      end
      4: begin m_data[31:0] = d; m_strb[3:0] = be; end
      5: begin m_data[63:32] = d; m_strb[7:4] = be; end
      default: ;
    endcase
  endtask

  task automatic model_complete();
    m_busy = 0; m_done = 1; m_err = slv_err;
    if (!m_op_wr) m_data = slv_rdata;
  endtask

  function automatic logic [31:0] exp_status(input logic b);
    return {26'd0, m_wr, m_ovr, m_tmo, m_err, m_done, b};
  endfunction

  // Bus drivers: entered and left 1 time unit after a rising edge
  task automatic cfg_read(input int idx, input logic [7:0] fn, output logic [31:0] d, output logic v);
    rd_rcv = 1'b1; reg_num = 10'(idx); fn_num = fn;
    @(posedge clk); #1;
    rd_rcv = 1'b0;
    d = rdata; v = rvalid;
  endtask

  task automatic cfg_write(input int idx, input logic [31:0] d, input logic [3:0] be, input logic [7:0] fn);
    wr_rcv = 1'b1; reg_num = 10'(idx); fn_num = fn; wdata = d; wbe = be;
    if (fn == 8'h00) model_write(idx, d, be);
    @(posedge clk); #1;
    wr_rcv = 1'b0;
  endtask

  task automatic wait_idle(output logic ok);
    int n;
    n = 0;
    while (psel && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    ok = !psel;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (rdata !== 32'd0 || rvalid !== 1'b0) begin bad++; $display("FAIL reset_cfg: got data=%h valid=%b want 0/0", rdata, rvalid); end
    total++; if ({psel, penable, pwrite} !== 3'b000) begin bad++; $display("FAIL reset_apb: got sel/en/wr=%b want 000", {psel, penable, pwrite}); end
    rst = 1'b0;
    model_reset();
    for (int i = 2; i <= 5; i++) begin
      cfg_read(B + i, 8'h00, d, v);
      total++; if (v !== 1'b1 || d !== 32'd0) begin bad++; $display("FAIL reset_reg%0d: got %h valid=%b want 0 valid=1", i, d, v); end
    end
  endtask

  task automatic test_headers();
    logic [31:0] d; logic v;
    cfg_read(B, 8'h00, d, v);
    total++; if (v !== 1'b1 || d !== 32'h0001000B) begin bad++; $display("FAIL cap_hdr: got %h valid=%b want 0001000b", d, v); end
    cfg_read(B + 1, 8'h00, d, v);
    total++; if (v !== 1'b1 || d !== 32'h018200FF) begin bad++; $display("FAIL vsec_hdr: got %h valid=%b want 018200ff", d, v); end
    cfg_read(B + 6, 8'h00, d, v);
    total++; if (v !== 1'b0 || d !== 32'd0) begin bad++; $display("FAIL out_of_range_hi: got %h valid=%b want 0/0", d, v); end
    cfg_read(B - 1, 8'h00, d, v);
    total++; if (v !== 1'b0) begin bad++; $display("FAIL out_of_range_lo: got valid=%b want 0", v); end
  endtask

  task automatic test_apb_write();
    logic [31:0] d; logic v; logic ok; apb_t t;
    log_q.delete();
    slv_wait = 1; slv_hang = 0; slv_err = 0;
    cfg_write(B + 2, 32'h0000_0010, 4'hF, 8'h00);
    cfg_write(B + 4, 32'hDEADBEEF, 4'hC, 8'h00);
    cfg_write(B + 3, 32'h2, 4'hF, 8'h00);
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL apb_write_timeout: psel still %b want 0", psel); end
    model_complete();
    total++;
    if (log_q.size() != 1) begin bad++; $display("FAIL apb_write_count: got %0d want 1", log_q.size()); end
    else begin
      t = log_q.pop_front();
      if (t.addr !== 32'h10 || t.wr !== 1'b1 || t.wdat[31:0] !== 32'hDEADBEEF || t.strb[3:0] !== 4'hC || t.prot !== 3'b010) begin
        bad++; $display("FAIL apb_write_xfer: got a=%h w=%b d=%h s=%h p=%b want 10/1/deadbeef/c/010", t.addr, t.wr, t.wdat[31:0], t.strb[3:0], t.prot);
      end
    end
    cfg_read(B + 3, 8'h00, d, v);
    total++; if (d !== 32'h22) begin bad++; $display("FAIL apb_write_status: got %h want 00000022", d); end
  endtask

  task automatic test_apb_read(input logic err);
    logic [31:0] d; logic v; logic ok; int pc0;
    log_q.delete();
    slv_wait = 3; slv_hang = 0; slv_err = err; slv_rdata = 64'hCAFEF00D_12345678;
    pc0 = psel_cycles;
    cfg_write(B + 3, 32'h1, 4'hF, 8'h00);
    wait_idle(ok);
    total++; if (!ok || psel_cycles - pc0 != 5) begin bad++; $display("FAIL apb_read_cycles: got %0d psel cycles want 5", psel_cycles - pc0); end
    model_complete();
    cfg_read(B + 3, 8'h00, d, v);
    total++; if (d !== (err ? 32'h06 : 32'h02)) begin bad++; $display("FAIL apb_read_status err=%b: got %h want %h", err, d, err ? 32'h06 : 32'h02); end
    cfg_read(B + 4, 8'h00, d, v);
    total++; if (d !== 32'h12345678) begin bad++; $display("FAIL apb_read_lo: got %h want 12345678", d); end
    cfg_read(B + 5, 8'h00, d, v);
    total++; if (d !== 32'hCAFEF00D) begin bad++; $display("FAIL apb_read_hi: got %h want cafef00d", d); end
  endtask

  task automatic test_overrun();
    logic [31:0] d; logic v; logic ok; logic [31:0] a0;
    slv_wait = 4; slv_hang = 0; slv_err = 0; slv_rdata = {$urandom, $urandom};
    a0 = m_addr;
    cfg_write(B + 3, 32'h1, 4'hF, 8'h00);
    cfg_read(B + 3, 8'h00, d, v);
    total++; if (d !== 32'h01) begin bad++; $display("FAIL busy_status: got %h want 00000001", d); end
    cfg_write(B + 2, 32'h5555_AAAA, 4'hF, 8'h00);
    cfg_write(B + 4, 32'h1111_2222, 4'hF, 8'h00);
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL overrun_timeout: psel still %b want 0", psel); end
    model_complete();
    cfg_read(B + 3, 8'h00, d, v);
    total++; if (d !== exp_status(1'b0) || d !== 32'h12) begin bad++; $display("FAIL overrun_status: got %h want 00000012", d); end
    cfg_read(B + 2, 8'h00, d, v);
    total++; if (d !== a0) begin bad++; $display("FAIL overrun_addr_kept: got %h want %h", d, a0); end
    cfg_read(B + 4, 8'h00, d, v);
    total++; if (d !== m_data[31:0]) begin bad++; $display("FAIL overrun_data: got %h want %h", d, m_data[31:0]); end
    cfg_write(B + 3, 32'h0, 4'hF, 8'h00);
    cfg_read(B + 3, 8'h00, d, v);
    total++; if (d !== 32'h00) begin bad++; $display("FAIL status_clear: got %h want 00000000", d); end
  endtask

  task automatic test_func_filter();
    logic [31:0] d; logic v; int pc0;
    cfg_read(B, 8'h01, d, v);
    total++; if (v !== 1'b0) begin bad++; $display("FAIL func_read: got valid=%b want 0", v); end
    pc0 = psel_cycles;
    cfg_write(B + 2, 32'hFFFF_0000, 4'hF, 8'h01);
    cfg_write(B + 3, 32'h2, 4'hF, 8'h01);
    repeat (6) @(posedge clk);
    #1;
    total++; if (psel_cycles != pc0) begin bad++; $display("FAIL func_apb: got %0d psel cycles want 0", psel_cycles - pc0); end
    cfg_read(B + 2, 8'h00, d, v);
    total++; if (d !== m_addr) begin bad++; $display("FAIL func_addr: got %h want %h", d, m_addr); end
  endtask

  task automatic test_back_to_back();
    logic ok;
    log_q.delete();
    slv_wait = 0; slv_hang = 0; slv_err = 0;
    cfg_write(B + 3, 32'h2, 4'hF, 8'h00);
    total++; if ({psel, penable} !== 2'b10) begin bad++; $display("FAIL setup_phase: got sel/en=%b want 10", {psel, penable}); end
    rd_rcv = 1'b1; reg_num = 10'(B + 3); fn_num = 8'h00;
    @(posedge clk); #1;
    total++; if (rvalid !== 1'b1 || rdata !== 32'h21) begin bad++; $display("FAIL b2b_n1: got %h valid=%b want 00000021", rdata, rvalid); end
    total++; if ({psel, penable} !== 2'b11) begin bad++; $display("FAIL access_phase: got sel/en=%b want 11", {psel, penable}); end
    @(posedge clk); #1;
    total++; if (rdata !== 32'h21) begin bad++; $display("FAIL b2b_m: got %h want 00000021", rdata); end
    total++; if (psel !== 1'b0) begin bad++; $display("FAIL idle_after: got psel=%b want 0", psel); end
    @(posedge clk); #1;
    rd_rcv = 1'b0;
    total++; if (rdata !== 32'h22) begin bad++; $display("FAIL b2b_m1: got %h want 00000022", rdata); end
    wait_idle(ok);
    model_complete();
    total++; if (log_q.size() != 1) begin bad++; $display("FAIL b2b_count: got %0d want 1", log_q.size()); end
    log_q.delete();
  endtask

  task automatic test_random();
    logic [31:0] d; logic v; logic ok; apb_t t;
    logic [31:0] a, lo, hi; logic [3:0] be0, be1; logic [1:0] op;
    for (int it = 0; it < 40; it++) begin
      log_q.delete();
      a = $urandom; lo = $urandom; hi = $urandom;
      be0 = 4'($urandom_range(0, 15)); be1 = 4'($urandom_range(0, 15));
      op = 2'($urandom_range(1, 3));
      slv_wait = $urandom_range(0, 4); slv_hang = 0;
      slv_err = 1'($urandom_range(0, 1)); slv_rdata = {$urandom, $urandom};
      cfg_write(B + 2, a, 4'hF, 8'h00);
      if ($urandom_range(0, 3) != 0) cfg_write(B + 4, lo, be0, 8'h00);
      if ($urandom_range(0, 3) != 0) cfg_write(B + 5, hi, be1, 8'h00);
      cfg_write(B + 3, 32'(op), 4'hF, 8'h00);
      if ($urandom_range(0, 2) == 0) cfg_write(B + 2 + $urandom_range(0, 3), $urandom, 4'hF, 8'h00);
      wait_idle(ok);
      total++;
      if (!ok || log_q.size() != 1) begin bad++; $display("FAIL rnd%0d_xfer_count: got %0d want 1", it, log_q.size()); end
      else begin
        t = log_q.pop_front();
        if (t.addr !== m_addr || t.wr !== op[1] || (op[1] && (t.wdat !== m_data || t.strb !== m_strb))) begin
          bad++; $display("FAIL rnd%0d_xfer: got a=%h w=%b d=%h s=%h want a=%h w=%b d=%h s=%h", it, t.addr, t.wr, t.wdat, t.strb, m_addr, op[1], m_data, m_strb);
        end
      end
      model_complete();
      cfg_read(B + 3, 8'h00, d, v);
      total++; if (d !== exp_status(1'b0)) begin bad++; $display("FAIL rnd%0d_status: got %h want %h", it, d, exp_status(1'b0)); end
      cfg_read(B + 4, 8'h00, d, v);
      total++; if (d !== m_data[31:0]) begin bad++; $display("FAIL rnd%0d_data_lo: got %h want %h", it, d, m_data[31:0]); end
      cfg_read(B + 5, 8'h00, d, v);
      total++; if (d !== m_data[63:32]) begin bad++; $display("FAIL rnd%0d_data_hi: got %h want %h", it, d, m_data[63:32]); end
      cfg_read(B + 2, 8'h00, d, v);
      total++; if (d !== m_addr) begin bad++; $display("FAIL rnd%0d_addr: got %h want %h", it, d, m_addr); end
    end
  endtask

`ifdef TAXI_PCIE_VSEC_APB_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] d; logic v; int n, g;
    slv_hang = 1'b1;
    cfg_write(B + 3, 32'h1, 4'hF, 8'h00);
    n = 0; g = 0;
    while (psel && g < 100) begin
      if (penable) n++;
      @(posedge clk); #1;
      g++;
    end
    total++; if (psel !== 1'b0 || n != 16) begin bad++; $display("FAIL timeout_len: got %0d access cycles want 16", n); end
    m_busy = 0; m_done = 1; m_tmo = 1;
    slv_hang = 1'b0;
    cfg_read(B + 3, 8'h00, d, v);
    total++; if (d !== 32'h0A) begin bad++; $display("FAIL timeout_status: got %h want 0000000a", d); end
    cfg_read(B + 4, 8'h00, d, v);
    total++; if (d !== m_data[31:0]) begin bad++; $display("FAIL timeout_data: got %h want %h", d, m_data[31:0]); end
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] d; logic v;
    slv_hang = 1'b1;
    cfg_write(B + 2, 32'hABCD_0000, 4'hF, 8'h00);
    cfg_write(B + 3, 32'h1, 4'hF, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    total++; if ({psel, penable} !== 2'b11) begin bad++; $display("FAIL hang_access: got sel/en=%b want 11", {psel, penable}); end
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if ({psel, penable} !== 2'b00) begin bad++; $display("FAIL reset_mid_apb: got sel/en=%b want 00", {psel, penable}); end
    rst = 1'b0;
    slv_hang = 1'b0;
    model_reset();
    cfg_read(B + 3, 8'h00, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_mid_status: got %h want 0", d); end
    cfg_read(B + 2, 8'h00, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_mid_addr: got %h want 0", d); end
  endtask

  initial begin
    rst = 1'b1; rd_rcv = 1'b0; wr_rcv = 1'b0; reg_num = '0; fn_num = '0; wdata = '0; wbe = '0;
    model_reset();
    test_reset();
    test_headers();
    test_apb_write();
    test_apb_read(1'b0);
    test_apb_read(1'b1);
    test_overrun();
    test_func_filter();
    test_back_to_back();
    test_random();
`ifdef TAXI_PCIE_VSEC_APB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
